// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl_if
// Brief    : Receiver capture, FIFO read port and status signals of uart_rx_ctrl.
// Revision : 1.0
// ============================================================================
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int c_LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  enable;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic                  clr_rx_done;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [c_LEVEL_W-1:0]  level;
    logic                  overrun;
    logic                  clr_overrun;
    logic                  timeout;

    modport master (
        output enable, rx_data, rx_done, rd_ready, clr_overrun,
        input  clr_rx_done, rd_data, rd_valid, level, overrun, timeout
    );

    modport slave (
        input  enable, rx_data, rx_done, rd_ready, clr_overrun,
        output clr_rx_done, rd_data, rd_valid, level, overrun, timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : Captures UART receiver characters into a show-ahead FIFO with
//            acknowledge handshake, overrun and character-timeout status.
// Revision : 1.0
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic     clk,
    input  wire logic     rst_l,
    uart_rx_ctrl_if.slave bus
);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LEVEL_W = c_PTR_W + 1;
    localparam int c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_LEVEL_W-1:0] c_FULL_LEVEL  = c_LEVEL_W'(FIFO_DEPTH);
    localparam logic [c_LEVEL_W-1:0] c_EMPTY_LEVEL = '0;
    localparam logic [c_CNT_W-1:0]   c_TMO_MAX     = c_CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_GUARD = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  clr_q, clr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_LEVEL_W-1:0]  level_q, level_d;
    logic                  overrun_q, overrun_d;
    logic [c_CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                  timeout_q, timeout_d;

    logic w_sample;
    logic w_pop;
    logic w_can_accept;
    logic w_push;
    logic w_drop;

    // rx_done is only looked at in IDLE; CLEAR/GUARD cover the receiver's fall time
    assign w_sample     = (state_q == c_ST_IDLE) && bus.rx_done;
    assign w_pop        = (level_q != c_EMPTY_LEVEL) && bus.rd_ready;
    assign w_can_accept = (level_q != c_FULL_LEVEL) || w_pop;
    assign w_push       = w_sample && bus.enable && w_can_accept;
    assign w_drop       = w_sample && bus.enable && !w_can_accept;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (bus.rx_done) state_d = c_ST_CLEAR;
            c_ST_CLEAR: state_d = c_ST_GUARD;
            c_ST_GUARD: state_d = c_ST_IDLE;
            default:    state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        clr_d = 1'b0;
        case (state_q)
            c_ST_IDLE: clr_d = bus.rx_done;
            default:   clr_d = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    // ---------------------------------------------------------------- status
    always_comb begin
        overrun_d = overrun_q;
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (w_push || w_pop || (level_q == c_EMPTY_LEVEL)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != c_TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Flag rises on the edge the counter lands on the limit, so both agree in the same cycle
    always_comb begin
        timeout_d = timeout_q;
        if (w_pop || (level_d == c_EMPTY_LEVEL)) begin
            timeout_d = 1'b0;
        end else if (tmo_cnt_d == c_TMO_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            clr_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            clr_q     <= clr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.clr_rx_done = clr_q;
    assign bus.rd_data     = mem_q[rd_ptr_q];
    assign bus.rd_valid    = (level_q != c_EMPTY_LEVEL);
    assign bus.level       = level_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Directed self-checking bench for uart_rx_ctrl (depth 8, timeout 16).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_ctrl;
    logic clk;
    logic rst_l;
    int   n_tests;
    int   n_fail;

    uart_rx_ctrl_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) u_if ();

    uart_rx_ctrl #(
        .DATA_WIDTH     (8),
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Each window starts 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full capture handshake starting in an IDLE window; ends in the next IDLE window.
    task automatic send_char(input logic [7:0] d);
        u_if.rx_data = d;
        u_if.rx_done = 1'b1;
        tick();
        u_if.rx_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        #12;
        n_tests++; if (u_if.clr_rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %b expected 0", u_if.clr_rx_done); end
        n_tests++; if (u_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", u_if.rd_valid); end
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", u_if.level); end
        n_tests++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", u_if.overrun); end
        n_tests++; if (u_if.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", u_if.timeout); end
        rst_l = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single();
        u_if.rx_data = 8'hA5;
        u_if.rx_done = 1'b1;
        tick();
        u_if.rx_done = 1'b0;
        n_tests++; if (u_if.clr_rx_done !== 1'b1) begin n_fail++; $display("FAIL single_clr_n1: got %b expected 1", u_if.clr_rx_done); end
        n_tests++; if (u_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", u_if.rd_valid); end
        n_tests++; if (u_if.level !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", u_if.level); end
        n_tests++; if (u_if.rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", u_if.rd_data); end
        tick();
        n_tests++; if (u_if.clr_rx_done !== 1'b0) begin n_fail++; $display("FAIL single_clr_n2: got %b expected 0", u_if.clr_rx_done); end
        tick();
        n_tests++; if (u_if.clr_rx_done !== 1'b0) begin n_fail++; $display("FAIL single_clr_n3: got %b expected 0", u_if.clr_rx_done); end
        u_if.rd_ready = 1'b1;
        tick();
        u_if.rd_ready = 1'b0;
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL single_pop_level: got %0d expected 0", u_if.level); end
        n_tests++; if (u_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", u_if.rd_valid); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) send_char(8'(i));
        n_tests++; if (u_if.level !== 4'd8) begin n_fail++; $display("FAIL ovr_full_level: got %0d expected 8", u_if.level); end
        n_tests++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b expected 0", u_if.overrun); end
        u_if.rx_data = 8'h08;
        u_if.rx_done = 1'b1;
        tick();
        u_if.rx_done = 1'b0;
        n_tests++; if (u_if.clr_rx_done !== 1'b1) begin n_fail++; $display("FAIL ovr_ack: got %b expected 1", u_if.clr_rx_done); end
        n_tests++; if (u_if.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", u_if.overrun); end
        n_tests++; if (u_if.level !== 4'd8) begin n_fail++; $display("FAIL ovr_level: got %0d expected 8", u_if.level); end
        tick();
        tick();
        u_if.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (u_if.rd_valid !== 1'b1 || u_if.rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovr_read%0d: got valid=%b data=%h expected valid=1 data=%h", i, u_if.rd_valid, u_if.rd_data, 8'(i)); end
            tick();
        end
        u_if.rd_ready = 1'b0;
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL ovr_drained: got %0d expected 0", u_if.level); end
        n_tests++; if (u_if.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", u_if.overrun); end
        u_if.clr_overrun = 1'b1;
        tick();
        u_if.clr_overrun = 1'b0;
        n_tests++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", u_if.overrun); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) send_char(8'h10 + 8'(i));
        n_tests++; if (u_if.level !== 4'd8) begin n_fail++; $display("FAIL fp_full: got %0d expected 8", u_if.level); end
        u_if.rx_data  = 8'h18;
        u_if.rx_done  = 1'b1;
        u_if.rd_ready = 1'b1;
        tick();
        u_if.rx_done  = 1'b0;
        u_if.rd_ready = 1'b0;
        n_tests++; if (u_if.level !== 4'd8) begin n_fail++; $display("FAIL fp_level: got %0d expected 8", u_if.level); end
        n_tests++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL fp_overrun: got %b expected 0", u_if.overrun); end
        n_tests++; if (u_if.rd_data !== 8'h11) begin n_fail++; $display("FAIL fp_head: got %h expected 11", u_if.rd_data); end
        tick();
        tick();
        u_if.rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_tests++; if (u_if.rd_data !== (8'h10 + 8'(i))) begin n_fail++; $display("FAIL fp_read%0d: got %h expected %h", i, u_if.rd_data, 8'h10 + 8'(i)); end
            tick();
        end
        u_if.rd_ready = 1'b0;
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL fp_drained: got %0d expected 0", u_if.level); end
    endtask

    task automatic test_timeout();
        u_if.rx_data = 8'h3C;
        u_if.rx_done = 1'b1;
        tick();
        u_if.rx_done = 1'b0;
        n_tests++; if (u_if.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_start: got %b expected 0", u_if.timeout); end
        for (int k = 1; k < 16; k++) tick();
        n_tests++; if (u_if.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", u_if.timeout); end
        tick();
        n_tests++; if (u_if.timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b expected 1", u_if.timeout); end
        n_tests++; if (u_if.level !== 4'd1) begin n_fail++; $display("FAIL tmo_level: got %0d expected 1", u_if.level); end
        u_if.rd_ready = 1'b1;
        tick();
        u_if.rd_ready = 1'b0;
        n_tests++; if (u_if.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", u_if.timeout); end
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL tmo_pop_level: got %0d expected 0", u_if.level); end
    endtask

    task automatic test_discard();
        u_if.enable  = 1'b0;
        u_if.rx_data = 8'h77;
        u_if.rx_done = 1'b1;
        tick();
        u_if.rx_done = 1'b0;
        n_tests++; if (u_if.clr_rx_done !== 1'b1) begin n_fail++; $display("FAIL disc_ack: got %b expected 1", u_if.clr_rx_done); end
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL disc_level: got %0d expected 0", u_if.level); end
        n_tests++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL disc_overrun: got %b expected 0", u_if.overrun); end
        tick();
        n_tests++; if (u_if.clr_rx_done !== 1'b0) begin n_fail++; $display("FAIL disc_ack_once: got %b expected 0", u_if.clr_rx_done); end
        tick();
        u_if.enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) send_char(8'h20 + 8'(i));
        u_if.rd_ready = 1'b1;
        repeat (5) tick();
        u_if.rd_ready = 1'b0;
        n_tests++; if (u_if.level !== 4'd3 || u_if.overrun !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got level=%0d overrun=%b expected level=3 overrun=1", u_if.level, u_if.overrun); end
        u_if.rx_data = 8'h29;
        u_if.rx_done = 1'b1;
        tick();
        u_if.rx_done = 1'b0;
        n_tests++; if (u_if.clr_rx_done !== 1'b1) begin n_fail++; $display("FAIL rm_clear_state: got %b expected 1", u_if.clr_rx_done); end
        rst_l = 1'b0;
        #1;
        n_tests++; if (u_if.clr_rx_done !== 1'b0) begin n_fail++; $display("FAIL rm_clr: got %b expected 0", u_if.clr_rx_done); end
        n_tests++; if (u_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", u_if.rd_valid); end
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL rm_level: got %0d expected 0", u_if.level); end
        n_tests++; if (u_if.overrun !== 1'b0) begin n_fail++; $display("FAIL rm_overrun: got %b expected 0", u_if.overrun); end
        n_tests++; if (u_if.timeout !== 1'b0) begin n_fail++; $display("FAIL rm_timeout: got %b expected 0", u_if.timeout); end
        #2;
        rst_l = 1'b1;
        tick();
        u_if.rx_data = 8'h5A;
        u_if.rx_done = 1'b1;
        tick();
        u_if.rx_done = 1'b0;
        n_tests++; if (u_if.clr_rx_done !== 1'b1) begin n_fail++; $display("FAIL rm_after_ack: got %b expected 1", u_if.clr_rx_done); end
        n_tests++; if (u_if.level !== 4'd1 || u_if.rd_data !== 8'h5A) begin n_fail++; $display("FAIL rm_after_data: got level=%0d data=%h expected level=1 data=5a", u_if.level, u_if.rd_data); end
        tick();
        tick();
        u_if.rd_ready = 1'b1;
        tick();
        u_if.rd_ready = 1'b0;
        n_tests++; if (u_if.level !== 4'd0) begin n_fail++; $display("FAIL rm_after_pop: got %0d expected 0", u_if.level); end
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst_l            = 1'b0;
        u_if.enable      = 1'b1;
        u_if.rx_data     = 8'h00;
        u_if.rx_done     = 1'b0;
        u_if.rd_ready    = 1'b0;
        u_if.clr_overrun = 1'b0;
        test_reset();
        test_single();
        test_overrun();
        test_full_pop();
        test_timeout();
        test_discard();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART integration design. Sits between the UART receiver and the downstream consumer. Captures each completed character from the receiver's `rx_data`/`rx_done` pair and acknowledges it through `clr_rx_done`. Buffers characters in a FIFO with a valid/ready read port, and reports overrun and character-timeout status.

## Interface
- `DATA_WIDTH`, 8: character width; matches the receiver's data width.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4096: idle cycles with data buffered before `timeout` asserts; ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_l`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = capture characters; 0 = discard them.
- `rx_data`  in  DATA_WIDTH  character from receiver; stable while `rx_done`=1.
- `rx_done`  in  1  receiver character-complete level.
- `clr_rx_done`  out  1  registered one-cycle acknowledge to receiver.
- `rd_data`  out  DATA_WIDTH  FIFO head (show-ahead); meaningful only when `rd_valid`=1.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts head; a pop occurs when `rd_valid`&`rd_ready`.
- `level`  out  $clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
- `overrun`  out  1  sticky; a character was dropped because the FIFO was full.
- `clr_overrun`  in  1  clears `overrun`.
- `timeout`  out  1  sticky character-timeout flag.

## Operation
- FSM states: IDLE, CLEAR, GUARD. Reset state is IDLE.
- `rx_done` is sampled only in IDLE.
- IDLE, `rx_done`=1:
  - `enable`=1 and the FIFO can accept: push `rx_data`.
  - `enable`=1 and the FIFO cannot accept: drop the character and set `overrun`.
  - `enable`=0: drop the character; `overrun` is unchanged.
  - In every case, register `clr_rx_done`<=1 and go to CLEAR.
- CLEAR: `clr_rx_done`=1 for exactly this cycle; go to GUARD.
- GUARD: `clr_rx_done`=0. The receiver's `rx_done` is falling this cycle. Go to IDLE unconditionally.
- Maximum capture rate is one character per 3 cycles.
- FIFO accept rule: the FIFO can accept when `level`<FIFO_DEPTH, or when a pop occurs on the same edge. Push and pop on the same edge leave `level` unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. Storage is not reset.
- `overrun`: set by a dropped push and cleared by `clr_overrun`; set wins if both occur on the same edge.
- Timeout counter:
  - Resets to 0 on any push, any pop, or when `level`=0.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
- `timeout` sets when the counter reaches TIMEOUT_CYCLES. It clears on any pop or when `level` becomes 0.

## Timing
- Reset values: `clr_rx_done`=0, `rd_valid`=0, `level`=0, `overrun`=0, `timeout`=0, FSM=IDLE, pointers=0, timeout counter=0.
- Reset asserted mid-sequence (CLEAR or GUARD) returns everything to reset values immediately. The receiver resets with the same `rst_l`, so no acknowledge is owed afterwards.
- Capture sequence, with IDLE seeing `rx_done`=1 in cycle N:
  - Edge N writes the FIFO.
  - Cycle N+1: `rd_valid`=1, `level` incremented, `clr_rx_done`=1.
  - Cycle N+2: GUARD.
  - Cycle N+3: IDLE, sampling `rx_done` again.
- A pop at edge M updates `rd_data`/`level` in cycle M+1. `rd_data` is a combinational read of the head entry.
- `overrun` is visible in cycle N+1 after a dropped character.
- `timeout` asserts TIMEOUT_CYCLES cycles after the last push/pop with no further activity. Counter starts at 0 in the cycle after that event.

## Test plan
- Single character: `rx_data`=0xA5, `rx_done`=1 at cycle N → `clr_rx_done`=1 only in N+1; `rd_valid`=1, `level`=1, `rd_data`=0xA5 in N+1; `rd_ready`=1 → `level`=0, `rd_valid`=0.
- Overrun: FIFO_DEPTH=8, push 0x00..0x08 with `rd_ready`=0 → `level`=8, `overrun`=1 after the ninth, ninth still acknowledged. Reads return 0x00..0x07 in order. `clr_overrun` → `overrun`=0.
- Full with simultaneous pop: `level`=8, `rd_ready`=1 on the push edge → push accepted, `level` stays 8, `overrun` stays 0, order preserved.
- Timeout: TIMEOUT_CYCLES=16, push one character, `rd_ready`=0 → `timeout`=1 exactly 16 cycles after the push cycle, not earlier. Pop → `timeout`=0, `level`=0.
- Discard: `enable`=0, `rx_done`=1 → `clr_rx_done` pulses once, `level` stays 0, `overrun` stays 0.
- Reset mid-sequence: assert `rst_l`=0 during CLEAR with `level`=3, `overrun`=1 → all outputs at reset values immediately. After release, the next character is captured normally.
